// File: rtl/dnnweaver_pkg.sv
// Shared dnnweaver definitions: weight_buffer geometry and the loader FSM state encoding.
package dnnweaver_pkg;

  // weight_buffer write-port geometry
  localparam int unsigned WbWrWidth     = 64;
  localparam int unsigned WbWrAddrWidth = 5;

  // weight_buffer_loader FSM states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } wbl_state_e;

endpackage

// File: rtl/weight_buffer_loader.sv
// weight_buffer_loader: streams cfg_num_words words from a valid/ready source into the
// weight_buffer write port, starting at cfg_base_addr and wrapping modulo the buffer depth.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   start                 : load request (sampled only while idle)
//   cfg_base_addr         : first write address, sampled with start
//   cfg_num_words         : word count, sampled with start (0 = immediate done)
//   s_data/s_valid/s_ready: input stream; s_ready depends on state only
//   write_req/_data/_addr : registered weight_buffer write port, one cycle after accept
//   busy                  : high while loading or signalling done
//   done                  : one-cycle completion pulse
module weight_buffer_loader
  import dnnweaver_pkg::*;
#(
  parameter int unsigned WR_WIDTH      = WbWrWidth,
  parameter int unsigned WR_ADDR_WIDTH = WbWrAddrWidth
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WR_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [WR_ADDR_WIDTH:0]   cfg_num_words,
  input  logic [WR_WIDTH-1:0]      s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     write_req,
  output logic [WR_WIDTH-1:0]      write_data,
  output logic [WR_ADDR_WIDTH-1:0] write_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CntW = WR_ADDR_WIDTH + 1;

  wbl_state_e               state_q;
  logic [WR_ADDR_WIDTH-1:0] addr_q;
  logic [CntW-1:0]          count_q;
  logic                     write_req_q;
  logic [WR_WIDTH-1:0]      write_data_q;
  logic [WR_ADDR_WIDTH-1:0] write_addr_q;
  logic                     done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      count_q      <= '0;
      write_req_q  <= 1'b0;
      write_data_q <= '0;
      write_addr_q <= '0;
      done_q       <= 1'b0;
    end else begin
      // Strobes default low; data/address registers hold their last value.
      write_req_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_num_words == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              addr_q  <= cfg_base_addr;
              count_q <= cfg_num_words;
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (s_valid) begin
            write_req_q  <= 1'b1;
            write_data_q <= s_data;
            write_addr_q <= addr_q;
            addr_q       <= addr_q + 1'b1;  // natural wrap at buffer depth
            count_q      <= count_q - 1'b1;
            // Last word: done pulse lines up with its write strobe.
            if (count_q == CntW'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign s_ready    = (state_q == StLoad);
  assign busy       = (state_q != StIdle);
  assign write_req  = write_req_q;
  assign write_data = write_data_q;
  assign write_addr = write_addr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Self-checking bench for weight_buffer_loader: a transaction-level model predicts every
// output each cycle; directed scenarios add literal checks on the captured write stream.
module tb_weight_buffer_loader;

  localparam int W     = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW:0]   cfg_num_words;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic          write_req;
  logic [W-1:0]  write_data;
  logic [AW-1:0] write_addr;
  logic          busy;
  logic          done;

  weight_buffer_loader #(
    .WR_WIDTH      (W),
    .WR_ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num_words (cfg_num_words),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .write_req     (write_req),
    .write_data    (write_data),
    .write_addr    (write_addr),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A load is "remaining words to take from the stream, starting at an address".
  bit           m_loading = 0;
  bit           m_in_done = 0;
  int           m_addr    = 0;
  int           m_remain  = 0;
  logic         exp_wreq  = 0;
  logic [W-1:0] exp_wdata = '0;
  logic [AW-1:0] exp_waddr = '0;
  logic         exp_done  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_loading = 0; m_in_done = 0; m_addr = 0; m_remain = 0;
      exp_wreq = 0; exp_wdata = '0; exp_waddr = '0; exp_done = 0;
    end else begin
      exp_wreq = 0;
      exp_done = 0;
      if (m_in_done) begin
        m_in_done = 0;
      end else if (m_loading) begin
        if (s_valid) begin
          exp_wreq  = 1;
          exp_wdata = s_data;
          exp_waddr = AW'(m_addr);
          m_addr    = (m_addr + 1) % DEPTH;
          m_remain  = m_remain - 1;
          if (m_remain == 0) begin
            m_loading = 0; m_in_done = 1; exp_done = 1;
          end
        end
      end else if (start) begin
        if (cfg_num_words == 0) begin
          m_in_done = 1; exp_done = 1;
        end else begin
          m_loading = 1; m_addr = int'(cfg_base_addr); m_remain = int'(cfg_num_words);
        end
      end
    end
  end

  // ---------------- compare + capture ----------------
  bit            chk_en = 0;
  logic [AW-1:0] wa[$];
  logic [W-1:0]  wd[$];
  int            done_cnt;
  logic          done_wreq;
  logic [AW-1:0] done_addr;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("write_req",  64'(write_req),  64'(exp_wreq));
      chk("write_data", write_data,      exp_wdata);
      chk("write_addr", 64'(write_addr), 64'(exp_waddr));
      chk("done",       64'(done),       64'(exp_done));
      chk("s_ready",    64'(s_ready),    64'(m_loading));
      chk("busy",       64'(busy),       64'(m_loading | m_in_done));
      if (write_req === 1'b1) begin
        wa.push_back(write_addr);
        wd.push_back(write_data);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_wreq = write_req;
        done_addr = write_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt  = 0;
    done_wreq = 1'b0;
    done_addr = '0;
  endtask

  task automatic begin_load(input int b, input int n);
    start = 1'b1;
    cfg_base_addr = AW'(b);
    cfg_num_words = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    s_valid = 1'b0;
    while ((m_loading || m_in_done) && c < budget) begin
      tick();
      c++;
    end
    if (m_loading || m_in_done) chk("drain_timeout", 64'(1), 64'(0));
    tick();
  endtask

  initial begin
    int errs;
    logic [AW-1:0] exp_a4[4];
    reset = 1'b1; start = 1'b0; cfg_base_addr = '0; cfg_num_words = '0;
    s_data = '0; s_valid = 1'b0;
    clear_log();
    tick();
    chk_en = 1;
    tick();
    reset = 1'b0;
    tick();

    // Full-depth load, data = index
    clear_log();
    begin_load(0, 32);
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1; s_data = W'(i); tick();
    end
    drain(10);
    chk("seq32_count", 64'(wa.size()), 64'd32);
    errs = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] != AW'(i) || wd[i] != W'(i)) errs++;
    chk("seq32_content", 64'(errs), 64'd0);
    chk("seq32_done_cnt", 64'(done_cnt), 64'd1);
    chk("seq32_done_with_wr", 64'(done_wreq), 64'd1);
    chk("seq32_done_addr", 64'(done_addr), 64'd31);

    // Address wrap
    clear_log();
    begin_load(30, 4);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = {$urandom, $urandom}; tick();
    end
    drain(10);
    chk("wrap_count", 64'(wa.size()), 64'd4);
    exp_a4 = '{5'd30, 5'd31, 5'd0, 5'd1};
    errs = 0;
    for (int i = 0; i < 4 && i < wa.size(); i++) if (wa[i] != exp_a4[i]) errs++;
    chk("wrap_addrs", 64'(errs), 64'd0);

    // Stalls: valid 1,0,1,0,1
    clear_log();
    begin_load(7, 3);
    for (int i = 0; i < 5; i++) begin
      s_valid = (i % 2 == 0); s_data = W'(100 + i); tick();
    end
    drain(10);
    chk("stall_count", 64'(wa.size()), 64'd3);
    chk("stall_last_data", (wd.size() == 3) ? wd[2] : 64'hdead, 64'd104);

    // Zero-length load
    clear_log();
    begin_load(12, 0);
    drain(5);
    chk("zero_writes", 64'(wa.size()), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Reset mid-load, word accepted in the reset cycle is dropped
    clear_log();
    begin_load(0, 8);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = W'(i + 1); tick();
    end
    reset = 1'b1; s_data = W'(99); tick();
    reset = 1'b0; s_valid = 1'b0;
    tick(); tick();
    chk("rst_writes", 64'(wa.size()), 64'd3);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);

    // start during load is ignored
    clear_log();
    begin_load(5, 6);
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1; s_data = W'(i);
      start = (i == 2); cfg_base_addr = 5'd20; cfg_num_words = 6'd2;
      tick();
    end
    start = 1'b0;
    drain(10);
    chk("ign_count", 64'(wa.size()), 64'd6);
    chk("ign_last_addr", (wa.size() == 6) ? 64'(wa[5]) : 64'hdead, 64'd10);

    // Randomized loads
    for (int n = 0; n < 25; n++) begin
      begin_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 45)));
      for (int c = 0; c < 400 && (m_loading || m_in_done); c++) begin
        s_valid = ($urandom_range(0, 9) < 7);
        s_data  = {$urandom, $urandom};
        start   = m_loading && ($urandom_range(0, 15) == 0);
        cfg_base_addr = AW'($urandom);
        cfg_num_words = (AW+1)'($urandom);
        reset   = ($urandom_range(0, 199) == 0);
        tick();
        start = 1'b0;
        reset = 1'b0;
      end
      if (m_loading || m_in_done) chk("rand_timeout", 64'(1), 64'(0));
      s_valid = 1'b0;
      tick();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_buffer_loader.md
WEIGHT_BUFFER_LOADER -- requirements
Module: weight_buffer_loader

Interface
REQ-001 SHALL have parameter WR_WIDTH, default 64, meaning write-word width in bits, equal to the weight_buffer write port width.
REQ-002 SHALL have parameter WR_ADDR_WIDTH, default 5, meaning weight_buffer write-address width; buffer depth is 2^WR_ADDR_WIDTH words.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: load request, sampled only in IDLE.
REQ-006 SHALL have port cfg_base_addr, input, WR_ADDR_WIDTH bits: first write address, sampled with start.
REQ-007 SHALL have port cfg_num_words, input, WR_ADDR_WIDTH+1 bits: number of words to load, sampled with start.
REQ-008 SHALL have port s_data, input, WR_WIDTH bits: stream data from the memory side.
REQ-009 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-010 SHALL have port s_ready, output, 1 bit: loader accepts s_data this cycle.
REQ-011 SHALL have port write_req, output, 1 bit: weight_buffer write strobe.
REQ-012 SHALL have port write_data, output, WR_WIDTH bits: weight_buffer write data.
REQ-013 SHALL have port write_addr, output, WR_ADDR_WIDTH bits: weight_buffer write address.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD and DONE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, LOAD, DONE.
REQ-017 In IDLE with start=1 and cfg_num_words>0, SHALL latch base address and count and enter LOAD on the next edge.
REQ-018 In IDLE with start=1 and cfg_num_words=0, SHALL enter DONE on the next edge with no write.
REQ-019 SHALL ignore start in LOAD and DONE; configuration is not re-sampled there.
REQ-020 s_ready SHALL equal (state==LOAD); it is combinational from state only, never from s_valid.
REQ-021 A transfer SHALL occur on each cycle with s_valid=1 and s_ready=1; a cycle with s_valid=0 SHALL stall without changing address or count.
REQ-022 For a transfer in cycle t, write_req SHALL be 1 in cycle t+1, with write_data equal to the accepted s_data and write_addr equal to the current address; otherwise write_req SHALL be 0. Write latency is exactly one cycle.
REQ-023 Current address SHALL increment by 1 per transfer modulo 2^WR_ADDR_WIDTH; for example, base 30 with count 4 writes 30, 31, 0, 1.
REQ-024 Count values above 2^WR_ADDR_WIDTH SHALL be honoured: writes wrap and overwrite earlier words.
REQ-025 On the transfer that exhausts the count, the FSM SHALL enter DONE on the next edge; s_ready is then 0, so no further word is accepted.
REQ-026 done SHALL be 1 exactly in the DONE cycle, coincident with the final write_req; the FSM SHALL return to IDLE the following edge.
REQ-027 write_data and write_addr SHALL hold their last values when write_req=0.

Reset
REQ-028 With reset=1 at an edge, SHALL set state=IDLE, write_req=0, done=0, write_addr=0, write_data=0, and clear internal count and address; s_ready and busy are therefore 0.
REQ-029 Reset during LOAD SHALL abandon the load immediately; no write_req SHALL appear after the reset edge, including a write for a word accepted in the cycle reset was asserted.

Structure
REQ-030 FSM state encoding SHALL reside in the shared dnnweaver package, alongside the weight_buffer width and address constants.
REQ-031 SHALL be a single module with no sub-modules; the counter and address register SHALL be inline.

Verification
REQ-032 Load base=0, count=32, s_valid held at 1 with data=index -> 32 writes to addresses 0..31, one per cycle, data 0..31; done in the cycle of the write to address 31.
REQ-033 Load base=30, count=4 -> writes to addresses 30, 31, 0, 1 in order.
REQ-034 Load count=3 with s_valid toggling 1,0,1,0,1 -> exactly 3 writes, each one cycle after its accept; no write in stall cycles.
REQ-035 Load count=0 -> done pulse one cycle after start, no write_req, s_ready never 1.
REQ-036 Load count=8, reset asserted after the 3rd accept -> 3 writes total, no further write_req, s_ready=0, and IDLE on the next edge.
REQ-037 start pulsed during LOAD with different configuration -> ignored; the original load completes unchanged.
